// File: rtl/bcd_display_scanner_pkg.sv
// Shared glyphs, digit-enable patterns and digit-triple type for the 3-digit scanner.
package bcd_display_scanner_pkg;

  // Segment glyphs, bit order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // One-cold digit enables, bit0 = units
  localparam logic [2:0] AN_U = 3'b110;
  localparam logic [2:0] AN_T = 3'b101;
  localparam logic [2:0] AN_H = 3'b011;

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] u;
  } bcd3_t;

  // Digit index -> digit-enable pattern
  function automatic logic [2:0] an_of(input logic [1:0] i);
    case (i)
      2'd0:    an_of = AN_U;
      2'd1:    an_of = AN_T;
      default: an_of = AN_H;
    endcase
  endfunction

endpackage

// File: rtl/bcd_display_scanner_seg7_decoder.sv
// Combinational BCD nibble to seven-segment glyph; non-BCD shows a dash.
module seg7_decoder
  import bcd_display_scanner_pkg::*;
(
  input  logic [3:0] val,
  input  logic       blank,
  output logic [6:0] seg
);

  // Glyph lookup, blank overrides everything
  always_comb begin
    seg = SEG_DASH;
    if (blank) seg = SEG_BLANK;
    else begin
      case (val)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 3-digit seven-segment scanner with frame-aligned double buffering
// and optional leading-zero blanking.
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int DIV = 4,
  parameter bit LZB = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] d100,
  input  logic [3:0] d10,
  input  logic [3:0] d1,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       pending,
  output logic       frame
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;
  logic [1:0]    idx, nidx;
  logic          tick, bnd, blank;
  bcd3_t         pbuf, active, nact, din;
  logic [3:0]    dval;
  logic [6:0]    seg_d;

  assign din  = {d100, d10, d1};
  assign tick = (cnt == CW'(DIV - 1));
  assign bnd  = tick && (idx == 2'd2);
  assign nidx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;

  // Value visible after this edge; the first digit of a new frame must already
  // see the committed value, so decode looks through the commit.
  always_comb begin
    nact = active;
    if (bnd) begin
      if (load)         nact = din;
      else if (pending) nact = pbuf;
    end
  end

  // Pick the digit for the next index and decide leading-zero blanking
  always_comb begin
    dval  = nact.u;
    blank = 1'b0;
    case (nidx)
      2'd1: begin
        dval  = nact.t;
        blank = LZB && (nact.h == 4'd0) && (nact.t == 4'd0);
      end
      2'd2: begin
        dval  = nact.h;
        blank = LZB && (nact.h == 4'd0);
      end
      default: ;
    endcase
  end

  seg7_decoder u_dec (
    .val   (dval),
    .blank (blank),
    .seg   (seg_d)
  );

  // Prescaler and digit index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= nidx;
    end
  end

  // Pending buffer, active value and frame pulse; a boundary always clears pending
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pbuf    <= '0;
      active  <= '0;
      pending <= 1'b0;
      frame   <= 1'b0;
    end else begin
      if (load) pbuf <= din;
      if (bnd)       pending <= 1'b0;
      else if (load) pending <= 1'b1;
      active <= nact;
      frame  <= bnd;
    end
  end

  // Registered display outputs, updated together on each dwell tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_0;
      an  <= AN_U;
    end else if (tick) begin
      seg <= seg_d;
      an  <= an_of(nidx);
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner, DIV=4, LZB=1.
module tb_bcd_display_scanner;

  logic       clk, rst, load;
  logic [3:0] d100, d10, d1;
  logic [6:0] seg;
  logic [2:0] an;
  logic       pending, frame;

  int checks = 0;
  int errors = 0;
  int ed = -1;  // index of the last rising edge since reset release

  bcd_display_scanner #(.DIV(4), .LZB(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .d100    (d100),
    .d10     (d10),
    .d1      (d1),
    .seg     (seg),
    .an      (an),
    .pending (pending),
    .frame   (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @edge %0d: observed %b expected %b", tag, ed, obs, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    @(negedge clk);
    ed++;
  endtask

  task automatic go(input int n);
    while (ed < n) tick1();
  endtask

  task automatic disp(input string tag, input logic [2:0] a, input logic [6:0] s);
    chk({tag, "_an"}, 32'(an), 32'(a));
    chk({tag, "_seg"}, 32'(seg), 32'(s));
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; d100 = 4'd0; d10 = 4'd0; d1 = 4'd0;
    repeat (3) @(negedge clk);
    // reset state
    disp("rst", 3'b110, 7'b0111111);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_frame", 32'(frame), 32'd0);
    rst = 1'b1;

    // idle scan with blanking
    go(2);  disp("idle_u0", 3'b110, 7'b0111111);
    go(3);  disp("idle_t", 3'b101, 7'b0000000);
    chk("idle_noframe", 32'(frame), 32'd0);
    go(7);  disp("idle_h", 3'b011, 7'b0000000);
    go(11); disp("idle_u1", 3'b110, 7'b0111111);
    chk("idle_frame", 32'(frame), 32'd1);
    go(12); chk("idle_frame_drop", 32'(frame), 32'd0);

    // single load 1/9/3 at cycle 2 of the frame starting at edge 12
    go(13);
    load = 1'b1; d100 = 4'd1; d10 = 4'd9; d1 = 4'd3;
    tick1(); load = 1'b0;
    chk("sl_pend_rise", 32'(pending), 32'd1);
    go(22); chk("sl_pend_hold", 32'(pending), 32'd1);
    disp("sl_old_h", 3'b011, 7'b0000000);
    go(23); chk("sl_pend_fall", 32'(pending), 32'd0);
    chk("sl_frame", 32'(frame), 32'd1);
    disp("sl_u", 3'b110, 7'b1001111);
    go(27); disp("sl_t", 3'b101, 7'b1101111);
    go(31); disp("sl_h", 3'b011, 7'b0000110);

    // overwrite: 0/4/2 then 2/5/5 before the boundary at edge 35
    go(32);
    load = 1'b1; d100 = 4'd0; d10 = 4'd4; d1 = 4'd2;
    tick1();
    d100 = 4'd2; d10 = 4'd5; d1 = 4'd5;
    tick1(); load = 1'b0;
    chk("ow_pend", 32'(pending), 32'd1);
    disp("ow_old_h", 3'b011, 7'b0000110);
    go(35); disp("ow_u", 3'b110, 7'b1101101);
    chk("ow_pend_fall", 32'(pending), 32'd0);
    go(36); chk("ow_pend_stay", 32'(pending), 32'd0);
    go(39); disp("ow_t", 3'b101, 7'b1101101);
    go(43); disp("ow_h", 3'b011, 7'b1011011);

    // bypass: load 0/0/7 exactly on the boundary edge 47
    go(46);
    load = 1'b1; d100 = 4'd0; d10 = 4'd0; d1 = 4'd7;
    tick1(); load = 1'b0;
    chk("bp_pend", 32'(pending), 32'd0);
    chk("bp_frame", 32'(frame), 32'd1);
    disp("bp_u", 3'b110, 7'b0000111);
    go(48); chk("bp_pend2", 32'(pending), 32'd0);
    go(51); disp("bp_t", 3'b101, 7'b0000000);
    go(55); disp("bp_h", 3'b011, 7'b0000000);

    // invalid digit: 0/12/0
    load = 1'b1; d100 = 4'd0; d10 = 4'd12; d1 = 4'd0;
    tick1(); load = 1'b0;
    chk("inv_pend", 32'(pending), 32'd1);
    go(59); disp("inv_u", 3'b110, 7'b0111111);
    go(63); disp("inv_t", 3'b101, 7'b1000000);
    go(67); disp("inv_h", 3'b011, 7'b0000000);

    // mid-frame reset with a pending 8/8/8
    go(75);
    load = 1'b1; d100 = 4'd8; d10 = 4'd8; d1 = 4'd8;
    tick1(); load = 1'b0;
    chk("mr_pend_pre", 32'(pending), 32'd1);
    chk("mr_an_pre", 32'(an), 32'(3'b101));
    #2 rst = 1'b0;
    #1;
    disp("mr_rst", 3'b110, 7'b0111111);
    chk("mr_rst_pend", 32'(pending), 32'd0);
    chk("mr_rst_frame", 32'(frame), 32'd0);
    // load during reset must be ignored
    load = 1'b1; d100 = 4'd9; d10 = 4'd9; d1 = 4'd9;
    tick1(); load = 1'b0;
    tick1();
    chk("mr_rst_hold_pend", 32'(pending), 32'd0);
    rst = 1'b1; ed = -1;
    go(2);  disp("mr_u0", 3'b110, 7'b0111111);
    chk("mr_pend_after", 32'(pending), 32'd0);
    go(3);  disp("mr_t", 3'b101, 7'b0000000);
    go(7);  disp("mr_h", 3'b011, 7'b0000000);
    go(11); disp("mr_u1", 3'b110, 7'b0111111);
    chk("mr_frame", 32'(frame), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
